// File: rtl/serial_pkg.sv
// Shared definitions for the serial front end: state encodings, idle-bit default
// and the counter sizing helper used by the serializer.
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic DEFAULT_IDLE_BIT = 1'b0;

  // A counter must hold WIDTH-1; never let the width collapse to zero.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes a WIDTH-bit word over valid/ready and emits
// it one registered bit per clock, with gap-free back-to-back words.
module piso_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done,
  output logic             busy
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic             sout_q;
  logic             sout_valid_q;
  logic             last_bit;
  logic             accept;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign last_bit  = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign din_ready = (state_q == ST_IDLE) || last_bit;
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit && !accept) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Counts bits still to come after the one on sout; 0 marks the last bit.
  always_ff @(posedge clk) begin
    if (rst)                                   cnt_q <= '0;
    else if (accept)                           cnt_q <= CNT_LOAD;
    else if (state_q == ST_SHIFT && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
  end

  // The head bit leaves at load time, so the register holds only the remainder.
  always_ff @(posedge clk) begin
    if (rst)                       shift_q <= '0;
    else if (accept)               shift_q <= advance(din);
    else if (state_q == ST_SHIFT)  shift_q <= advance(shift_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
    end else if (accept) begin
      sout_q       <= head_bit(din);
      sout_valid_q <= 1'b1;
    end else if (state_q == ST_SHIFT && !last_bit) begin
      sout_q       <= head_bit(shift_q);
      sout_valid_q <= 1'b1;
    end else begin
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign done       = last_bit;
  assign busy       = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: three serializer variants driven in lockstep and compared
// every cycle against a bit-queue model of the serial stream.
module tb_piso_serializer;

  localparam int NDUT = 3;
  localparam int        widthOf [NDUT] = '{8, 8, 3};
  localparam bit        msbOf   [NDUT] = '{1'b1, 1'b0, 1'b1};
  localparam logic      idleOf  [NDUT] = '{1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst;
  logic       dinValid;
  logic [7:0] din;

  logic obsReady [NDUT];
  logic obsSout  [NDUT];
  logic obsValid [NDUT];
  logic obsDone  [NDUT];
  logic obsBusy  [NDUT];

  logic modelQ [NDUT][$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dutMsb8 (
    .clk(clk), .rst(rst), .din_valid(dinValid), .din(din),
    .din_ready(obsReady[0]), .sout(obsSout[0]), .sout_valid(obsValid[0]),
    .done(obsDone[0]), .busy(obsBusy[0])
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dutLsb8 (
    .clk(clk), .rst(rst), .din_valid(dinValid), .din(din),
    .din_ready(obsReady[1]), .sout(obsSout[1]), .sout_valid(obsValid[1]),
    .done(obsDone[1]), .busy(obsBusy[1])
  );

  piso_serializer #(.WIDTH(3), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dutMsb3 (
    .clk(clk), .rst(rst), .din_valid(dinValid), .din(din[2:0]),
    .din_ready(obsReady[2]), .sout(obsSout[2]), .sout_valid(obsValid[2]),
    .done(obsDone[2]), .busy(obsBusy[2])
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // The model's queue holds the bits still to appear; its front is the bit on sout now.
  task automatic modelEdge(input logic r, input logic v, input logic [7:0] w);
    for (int i = 0; i < NDUT; i++) begin
      if (r) begin
        modelQ[i].delete();
      end else begin
        automatic bit ready = (modelQ[i].size() <= 1);
        if (modelQ[i].size() > 0) void'(modelQ[i].pop_front());
        if (v && ready)
          for (int b = 0; b < widthOf[i]; b++)
            modelQ[i].push_back(msbOf[i] ? w[widthOf[i]-1-b] : w[b]);
      end
    end
  endtask

  task automatic compareAll();
    for (int i = 0; i < NDUT; i++) begin
      automatic int   n       = modelQ[i].size();
      automatic logic expSout = (n > 0) ? modelQ[i][0] : idleOf[i];
      checkOutput($sformatf("dut%0d.sout", i),       8'(obsSout[i]),  8'(expSout));
      checkOutput($sformatf("dut%0d.sout_valid", i), 8'(obsValid[i]), 8'(n > 0));
      checkOutput($sformatf("dut%0d.done", i),       8'(obsDone[i]),  8'(n == 1));
      checkOutput($sformatf("dut%0d.din_ready", i),  8'(obsReady[i]), 8'(n <= 1));
      checkOutput($sformatf("dut%0d.busy", i),       8'(obsBusy[i]),  8'(n > 0));
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, then compare.
  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] w);
    rst      = r;
    dinValid = v;
    din      = w;
    @(posedge clk);
    modelEdge(r, v, w);
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    logic [7:0] captured;
    logic [7:0] curWord;
    bit         accepted0;

    rst = 1'b1; dinValid = 1'b0; din = 8'h00;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);

    $display("[TB] single MSB-first word 8'hA5");
    applyStimulus(1'b0, 1'b1, 8'hA5);
    captured = 8'h00;
    captured = {captured[6:0], obsSout[0]};
    for (int c = 2; c <= 8; c++) begin
      applyStimulus(1'b0, 1'b0, 8'h00);
      captured = {captured[6:0], obsSout[0]};
    end
    checkOutput("a5.collected_bits", captured, 8'hA5);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("a5.idle_sout", 8'(obsSout[0]), 8'h00);

    $display("[TB] back-to-back 8'hF0 then 8'h0F");
    applyStimulus(1'b0, 1'b1, 8'hF0);
    for (int c = 0; c < 8; c++) applyStimulus(1'b0, 1'b1, 8'h0F);
    for (int c = 0; c < 9; c++) applyStimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] reset mid-word, then 8'h81");
    applyStimulus(1'b0, 1'b1, 8'hFF);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h81);
    for (int c = 0; c < 9; c++) applyStimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] stall: 8'h01 then 8'hFF held from cycle 3");
    applyStimulus(1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 6; c++) applyStimulus(1'b0, 1'b1, 8'hFF);
    for (int c = 0; c < 9; c++) applyStimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] randomized traffic");
    curWord  = 8'($urandom);
    for (int c = 0; c < 400; c++) begin
      automatic logic r = ($urandom_range(0, 99) < 2);
      automatic logic v = ($urandom_range(0, 99) < 65);
      accepted0 = v && !r && (modelQ[0].size() <= 1);
      applyStimulus(r, v, curWord);
      if (accepted0 || !v) curWord = 8'($urandom);
    end
    for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
